cnu_min2_stream: RTL and testbench

//  Streaming, degree-programmable two-minimum finder for the layered decoder's check-node units.
//  - Accepts one decoded magnitude per beat and tracks exact min1/min2 and both indices.
//  - After cfg_degree beats, publishes {m1, m2, min_1_index, min_2_index} via a valid/ready output.
//  - A one-deep result register lets the next row accumulate while the previous result waits.

---
 rtl/cnu_min2_stream.sv | 148 ++++++++++++++
 tb/tb_cnu_min2_stream.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cnu_min2_stream.sv
// Streaming two-minimum finder for check-node units: tracks min1/min2 and their
// beat positions over a programmable-degree frame, with a one-deep result register.
module cnu_min2_stream #(
   parameter int MAX_DEGREE     = 10,
   parameter int QUAN_SIZE      = 3,
   parameter int INDEX_BITWIDTH = $clog2(MAX_DEGREE),
   parameter int DEG_W          = $clog2(MAX_DEGREE + 1)
) (
   input  logic                      sys_clk,
   input  logic                      rstn,
   input  logic                      clr,
   input  logic [DEG_W-1:0]          cfg_degree,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [QUAN_SIZE-1:0]      in_msg,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [QUAN_SIZE-1:0]      m1,
   output logic [QUAN_SIZE-1:0]      m2,
   output logic [INDEX_BITWIDTH-1:0] min_1_index,
   output logic [INDEX_BITWIDTH-1:0] min_2_index,
   output logic                      deg_err
);

   typedef enum logic {IDLE, ACC} state_e;

   state_e                    state_q, state_d;
   logic [DEG_W-1:0]          cnt_q, cnt_d, deg_q, deg_d;
   logic                      err_q, err_d;
   logic [QUAN_SIZE-1:0]      min1_q, min1_d, min2_q, min2_d;
   logic [INDEX_BITWIDTH-1:0] idx1_q, idx1_d, idx2_q, idx2_d;

   logic                      ov_q, ov_d, rerr_q;
   logic [QUAN_SIZE-1:0]      rm1_q, rm2_q;
   logic [INDEX_BITWIDTH-1:0] ri1_q, ri2_q;

   logic                      beat, last, load, bad_deg;
   logic [INDEX_BITWIDTH-1:0] pos;
   logic [QUAN_SIZE-1:0]      u_min1, u_min2;
   logic [INDEX_BITWIDTH-1:0] u_idx1, u_idx2;

   // Only the closing beat must wait for the result register to drain.
   assign last     = (state_q == ACC) && (cnt_q == deg_q - DEG_W'(1));
   assign in_ready = !(last && ov_q && !out_ready);
   assign beat     = in_valid && in_ready;
   assign pos      = INDEX_BITWIDTH'(cnt_q);
   assign bad_deg  = (cfg_degree < DEG_W'(2)) || (cfg_degree > DEG_W'(MAX_DEGREE));

   // Strict compares keep the earlier position on ties.
   always_comb begin
      u_min1 = min1_q;
      u_min2 = min2_q;
      u_idx1 = idx1_q;
      u_idx2 = idx2_q;
      if (in_msg < min1_q) begin
         u_min2 = min1_q;
         u_idx2 = idx1_q;
         u_min1 = in_msg;
         u_idx1 = pos;
      end else if (in_msg < min2_q) begin
         u_min2 = in_msg;
         u_idx2 = pos;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      deg_d   = deg_q;
      err_d   = err_q;
      min1_d  = min1_q;
      min2_d  = min2_q;
      idx1_d  = idx1_q;
      idx2_d  = idx2_q;
      load    = 1'b0;
      if (clr || (beat && last)) begin
         load    = !clr;
         state_d = IDLE;
         cnt_d   = '0;
         min1_d  = '1;
         min2_d  = '1;
         idx1_d  = '0;
         idx2_d  = '0;
      end else if (beat) begin
         if (state_q == IDLE) begin
            state_d = ACC;
            cnt_d   = DEG_W'(1);
            deg_d   = bad_deg ? DEG_W'(MAX_DEGREE) : cfg_degree;
            err_d   = bad_deg;
            min1_d  = in_msg;
            idx1_d  = '0;
            min2_d  = '1;
            idx2_d  = '0;
         end else begin
            cnt_d  = cnt_q + DEG_W'(1);
            min1_d = u_min1;
            min2_d = u_min2;
            idx1_d = u_idx1;
            idx2_d = u_idx2;
         end
      end
      ov_d = load || (ov_q && !out_ready);
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         deg_q   <= '0;
         err_q   <= 1'b0;
         min1_q  <= '1;
         min2_q  <= '1;
         idx1_q  <= '0;
         idx2_q  <= '0;
         ov_q    <= 1'b0;
         rm1_q   <= '0;
         rm2_q   <= '0;
         ri1_q   <= '0;
         ri2_q   <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         deg_q   <= deg_d;
         err_q   <= err_d;
         min1_q  <= min1_d;
         min2_q  <= min2_d;
         idx1_q  <= idx1_d;
         idx2_q  <= idx2_d;
         ov_q    <= ov_d;
         if (load) begin
            rm1_q  <= u_min1;
            rm2_q  <= u_min2;
            ri1_q  <= u_idx1;
            ri2_q  <= u_idx2;
            rerr_q <= err_q;
         end
      end
   end

   assign out_valid   = ov_q;
   assign m1          = rm1_q;
   assign m2          = rm2_q;
   assign min_1_index = ri1_q;
   assign min_2_index = ri2_q;
   assign deg_err     = rerr_q;

endmodule

// File: tb/tb_cnu_min2_stream.sv
// Scoreboard bench for cnu_min2_stream: directed frames push expected results,
// a posedge monitor compares every presented result against the queue head.
module tb_cnu_min2_stream;

   logic       sys_clk = 1'b0;
   logic       rstn = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] cfg_degree = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_msg = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [2:0] m1, m2;
   logic [3:0] min_1_index, min_2_index;
   logic       deg_err;

   int checks = 0;
   int failures = 0;
   logic [14:0] sb[$];

   cnu_min2_stream dut (
      .sys_clk(sys_clk), .rstn(rstn), .clr(clr), .cfg_degree(cfg_degree),
      .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
      .out_valid(out_valid), .out_ready(out_ready), .m1(m1), .m2(m2),
      .min_1_index(min_1_index), .min_2_index(min_2_index), .deg_err(deg_err)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [14:0] ex(int a, int b, int i, int j, int e);
      return {3'(a), 3'(b), 4'(i), 4'(j), 1'(e)};
   endfunction

   task automatic chk(string name, int act, int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat is accepted.
   task automatic beat(int deg, int msg);
      int guard = 0;
      cfg_degree = 4'(deg);
      in_msg = 3'(msg);
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(negedge sys_clk);
         guard++;
      end
      if (guard >= 50) chk("beat_timeout", 0, 1);
      @(negedge sys_clk);
      in_valid = 1'b0;
   endtask

   always @(posedge sys_clk) begin
      if (rstn && out_valid) begin
         if (sb.size() == 0) chk("unexpected_result", 1, 0);
         else begin
            chk("result", int'({m1, m2, min_1_index, min_2_index, deg_err}), int'(sb[0]));
            if (out_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      int guard;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_data", int'({m1, m2, min_1_index, min_2_index, deg_err}), 0);
      @(negedge sys_clk);
      rstn = 1'b1;
      @(negedge sys_clk);

      // 1: basic frame and one-cycle latency
      sb.push_back(ex(1, 2, 3, 5, 0));
      beat(6, 5); beat(6, 3); beat(6, 6); beat(6, 1); beat(6, 4);
      chk("t1_not_early", out_valid, 0);
      beat(6, 2);
      chk("t1_latency", out_valid, 1);

      // 2: ties keep the earlier index
      sb.push_back(ex(2, 2, 0, 1, 0));
      beat(4, 2); beat(4, 2); beat(4, 7); beat(4, 2);

      // 3: back-to-back with a stalled consumer
      @(negedge sys_clk);
      out_ready = 1'b0;
      sb.push_back(ex(1, 3, 1, 2, 0));
      sb.push_back(ex(0, 0, 0, 2, 0));
      beat(3, 4); beat(3, 1); beat(3, 3);
      beat(3, 0); beat(3, 6);
      in_msg = 3'd0;
      in_valid = 1'b1;
      repeat (3) begin
         chk("t3_stall_in_ready", in_ready, 0);
         @(negedge sys_clk);
      end
      chk("t3_held_valid", out_valid, 1);
      out_ready = 1'b1;
      #1 chk("t3_release_in_ready", in_ready, 1);
      @(negedge sys_clk);
      in_valid = 1'b0;
      chk("t3_second_loaded", out_valid, 1);
      @(negedge sys_clk);

      // 4: out-of-range degrees clamp to 10 and flag deg_err
      sb.push_back(ex(1, 1, 7, 9, 1));
      beat(0, 3); beat(0, 5); beat(0, 2); beat(0, 7); beat(0, 2);
      beat(0, 6); beat(0, 4); beat(0, 1); beat(0, 5); beat(0, 1);
      @(negedge sys_clk);
      sb.push_back(ex(6, 7, 8, 0, 1));
      for (int k = 0; k < 8; k++) beat(11, 7);
      beat(11, 6);
      chk("t4_len10_not_done", out_valid, 0);
      beat(11, 7);
      chk("t4_len10_done", out_valid, 1);
      @(negedge sys_clk);

      // 5: clr mid-frame drops the beat and the partial frame, result untouched
      out_ready = 1'b0;
      sb.push_back(ex(3, 5, 1, 0, 0));
      beat(2, 5); beat(2, 3);
      beat(5, 0); beat(5, 0);
      in_msg = 3'd0;
      in_valid = 1'b1;
      clr = 1'b1;
      @(negedge sys_clk);
      clr = 1'b0;
      in_valid = 1'b0;
      chk("t5_held_after_clr", out_valid, 1);
      sb.push_back(ex(1, 3, 2, 4, 0));
      beat(5, 4); beat(5, 6); beat(5, 1); beat(5, 6);
      out_ready = 1'b1;
      beat(5, 3);
      @(negedge sys_clk);

      // 6: async reset mid-frame with a pending result
      out_ready = 1'b0;
      sb.push_back(ex(1, 2, 2, 0, 0));
      beat(3, 2); beat(3, 4); beat(3, 1);
      beat(4, 5);
      #2 rstn = 1'b0;
      #1;
      chk("t6_rst_out_valid", out_valid, 0);
      chk("t6_rst_in_ready", in_ready, 1);
      chk("t6_rst_data", int'({m1, m2, min_1_index, min_2_index, deg_err}), 0);
      sb.delete();
      @(negedge sys_clk);
      rstn = 1'b1;
      out_ready = 1'b1;
      @(negedge sys_clk);
      sb.push_back(ex(4, 4, 0, 1, 0));
      beat(2, 4); beat(2, 4);

      guard = 0;
      while (sb.size() != 0 && guard < 50) begin
         @(negedge sys_clk);
         guard++;
      end
      chk("drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
